// File: rtl/calc_pkg.sv
// ----------------------------------------------------------------------------
// calc_pkg
// Shared constants for the calculator arithmetic units (divider, multiplier).
//   CALC_W       : default operand width shared by the divider and multiplier
//   mul_state_t  : 3-bit state code of the sequential multiplier
//   MUL_IDLE..MUL_DONE : state codes (shown on the CS debug/LED port)
//   mul_state_legal()  : helper flagging the two unused codes (6, 7)
// ----------------------------------------------------------------------------
package calc_pkg;

  localparam int CALC_W = 4;

  typedef logic [2:0] mul_state_t;

  localparam logic [2:0] MUL_IDLE  = 3'd0;
  localparam logic [2:0] MUL_LOAD  = 3'd1;
  localparam logic [2:0] MUL_TEST  = 3'd2;
  localparam logic [2:0] MUL_ADD   = 3'd3;
  localparam logic [2:0] MUL_SHIFT = 3'd4;
  localparam logic [2:0] MUL_DONE  = 3'd5;

  // Codes above MUL_DONE are never entered legally; the FSM recovers to IDLE.
  function automatic logic mul_state_legal(input logic [2:0] st);
    return (st <= MUL_DONE);
  endfunction

endpackage

// File: rtl/mul_bit_counter.sv
// ----------------------------------------------------------------------------
// mul_bit_counter
// Loadable down counter tracking how many multiplier bits remain.
//   CLK       : clock, rising edge
//   rst       : asynchronous active-high reset (count -> 0)
//   LD        : load ld_val (has priority over CE)
//   CE        : decrement by one
//   ld_val    : value loaded on LD
//   count     : current count (registered)
//   count_one : count == 1, i.e. the next decrement finishes the operation
// ----------------------------------------------------------------------------
module mul_bit_counter #(
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             LD,
  input  logic             CE,
  input  logic [CNT_W-1:0] ld_val,
  output logic [CNT_W-1:0] count,
  output logic             count_one
);

  logic [CNT_W-1:0] count_r;

  // Counter register: load, decrement or hold.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (LD) begin
      count_r <= ld_val;
    end else if (CE) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count     = count_r;
  // The FSM leaves SHIFT on this flag, so the counter never wraps below zero.
  assign count_one = (count_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/multiplier_seq.sv
// ----------------------------------------------------------------------------
// multiplier_seq
// Sequential shift-and-add unsigned multiplier with a Go/Done/Err handshake
// matching the restoring divider of the calculator.
//   CLK  : clock, rising edge
//   rst  : asynchronous active-high reset; aborts any operation, no Done
//   Go   : start request, sampled only in IDLE
//   X    : multiplier operand (held stable from Go through LOAD)
//   Y    : multiplicand operand (held stable from Go through LOAD)
//   P    : product {A[WIDTH-1:0], Q}; valid with Done, held until next LOAD
//   Done : one-cycle pulse in the DONE state
//   Err  : product overflows WIDTH bits (valid with Done)
//   Busy : high in every state except IDLE
//   CS   : current state code for debug/LED display
//
// Build option: define MUL_OVF_DETECT_EN to enable the overflow flag on Err.
// Without it Err is tied low but the port is kept for unchanged wiring.
//
// Latency from LOAD to the Done cycle inclusive is 2 + 2*WIDTH + popcount(X);
// a zero operand short-cuts LOAD -> DONE (2 cycles). All outputs come from
// registers or decode of the state register only.
// ----------------------------------------------------------------------------
module multiplier_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_W,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               Go,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic [2*WIDTH-1:0] P,
  output logic               Done,
  output logic               Err,
  output logic               Busy,
  output logic [2:0]         CS
);

  mul_state_t       state_r;
  mul_state_t       next_state_s;

  // A carries one extra bit so the ADD carry is never lost.
  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;

  logic             zero_op_s;
  logic             cnt_ld_s;
  logic             cnt_ce_s;
  logic [CNT_W-1:0] cnt_s;
  logic             cnt_one_s;

  assign zero_op_s = (X == {WIDTH{1'b0}}) || (Y == {WIDTH{1'b0}});
  assign cnt_ld_s  = (state_r == MUL_LOAD);
  assign cnt_ce_s  = (state_r == MUL_SHIFT);

  mul_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .CLK       (CLK),
    .rst       (rst),
    .LD        (cnt_ld_s),
    .CE        (cnt_ce_s),
    .ld_val    (CNT_W'(WIDTH)),
    .count     (cnt_s),
    .count_one (cnt_one_s)
  );

  // Next-state decode; unused codes fall back to IDLE.
  always_comb begin
    next_state_s = MUL_IDLE;
    if (!mul_state_legal(state_r)) begin
      next_state_s = MUL_IDLE;
    end else begin
      case (state_r)
        MUL_IDLE: begin
          if (Go) begin
            next_state_s = MUL_LOAD;
          end else begin
            next_state_s = MUL_IDLE;
          end
        end
        MUL_LOAD: begin
          if (zero_op_s) begin
            next_state_s = MUL_DONE;
          end else begin
            next_state_s = MUL_TEST;
          end
        end
        MUL_TEST: begin
          if (q_r[0]) begin
            next_state_s = MUL_ADD;
          end else begin
            next_state_s = MUL_SHIFT;
          end
        end
        MUL_ADD:   next_state_s = MUL_SHIFT;
        MUL_SHIFT: begin
          if (cnt_one_s) begin
            next_state_s = MUL_DONE;
          end else begin
            next_state_s = MUL_TEST;
          end
        end
        MUL_DONE:  next_state_s = MUL_IDLE;
        default:   next_state_s = MUL_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_r <= MUL_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath: A/Q/M only change in LOAD, ADD and SHIFT, so P holds otherwise.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      a_r <= {(WIDTH+1){1'b0}};
      q_r <= {WIDTH{1'b0}};
      m_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        MUL_LOAD: begin
          a_r <= {(WIDTH+1){1'b0}};
          m_r <= Y;
          // Clearing Q on the zero fast path makes P read 0 even when only Y is 0.
          q_r <= zero_op_s ? {WIDTH{1'b0}} : X;
        end
        MUL_ADD: begin
          a_r <= a_r + {1'b0, m_r};
        end
        MUL_SHIFT: begin
          {a_r, q_r} <= {1'b0, a_r, q_r[WIDTH-1:1]};
        end
        default: begin
          a_r <= a_r;
          q_r <= q_r;
          m_r <= m_r;
        end
      endcase
    end
  end

  assign P    = {a_r[WIDTH-1:0], q_r};
  assign Done = (state_r == MUL_DONE);
  assign Busy = (state_r != MUL_IDLE);
  assign CS   = state_r;

`ifdef MUL_OVF_DETECT_EN
  // A[WIDTH] is always 0 after the final SHIFT, so the upper half is A[WIDTH-1:0].
  assign Err = (state_r == MUL_DONE) && (a_r[WIDTH-1:0] != {WIDTH{1'b0}});
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_seq.sv
// ----------------------------------------------------------------------------
// tb_multiplier_seq
// Directed bench for multiplier_seq (WIDTH=4). Inputs change on the falling
// edge, outputs are sampled on the falling edge. Expected products, latencies
// and overflow flags are hand computed.
// ----------------------------------------------------------------------------
module tb_multiplier_seq;

  logic       CLK;
  logic       rst;
  logic       Go;
  logic [3:0] X;
  logic [3:0] Y;
  logic [7:0] P;
  logic       Done;
  logic       Err;
  logic       Busy;
  logic [2:0] CS;

  int n_cmp;
  int n_bad;

  multiplier_seq #(.WIDTH(4)) dut (
    .CLK  (CLK),
    .rst  (rst),
    .Go   (Go),
    .X    (X),
    .Y    (Y),
    .P    (P),
    .Done (Done),
    .Err  (Err),
    .Busy (Busy),
    .CS   (CS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected overflow flag in the Done cycle for a given product.
  function automatic logic exp_err(input logic [7:0] p);
`ifdef MUL_OVF_DETECT_EN
    return (p[7:4] != 4'd0);
`else
    return 1'b0;
`endif
  endfunction

  // One operation: Go pulse, wait for Done (bounded), check latency/P/Err/Busy,
  // then the following IDLE cycle. disturb toggles Go and X/Y mid-operation.
  task automatic run_op(input string tag, input logic [3:0] x, input logic [3:0] y,
                        input logic [7:0] p_exp, input int lat, input logic disturb);
    int  n;
    int  busy_n;
    logic seen;
    n = 0; busy_n = 0; seen = 1'b0;
    @(negedge CLK);
    X = x; Y = y; Go = 1'b1;
    @(negedge CLK);
    Go = 1'b0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      if (i > 1) @(negedge CLK);
      n = i;
      if (Busy) busy_n++;
      if (Done) seen = 1'b1;
      if (disturb && i == 3) begin
        X = 4'hF; Y = 4'hF; Go = 1'b1;
      end
      if (disturb && i == 5) begin
        Go = 1'b0;
      end
    end
    check_eq({tag, " done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, " latency"}, 32'(n), 32'(lat));
    check_eq({tag, " P"}, 32'(P), 32'(p_exp));
    check_eq({tag, " Err"}, 32'(Err), 32'(exp_err(p_exp)));
    check_eq({tag, " busy_cycles"}, 32'(busy_n), 32'(lat));
    @(negedge CLK);
    check_eq({tag, " idle_done"}, 32'(Done), 32'd0);
    check_eq({tag, " idle_err"}, 32'(Err), 32'd0);
    check_eq({tag, " idle_cs"}, 32'(CS), 32'd0);
    check_eq({tag, " held_P"}, 32'(P), 32'(p_exp));
  endtask

  initial begin
    int   gap;
    logic seen;
    n_cmp = 0; n_bad = 0;
    Go = 1'b0; X = 4'd0; Y = 4'd0;
    rst = 1'b1;
    repeat (2) @(negedge CLK);
    check_eq("rst CS", 32'(CS), 32'd0);
    check_eq("rst Busy", 32'(Busy), 32'd0);
    check_eq("rst Done", 32'(Done), 32'd0);
    check_eq("rst Err", 32'(Err), 32'd0);
    check_eq("rst P", 32'(P), 32'd0);
    rst = 1'b0;
    @(negedge CLK);

    // 13*11=143, popcount(13)=3
    run_op("13x11", 4'd13, 4'd11, 8'h8F, 13, 1'b0);
    // 15*15=225, carry into A[4]
    run_op("15x15", 4'd15, 4'd15, 8'hE1, 14, 1'b0);
    // zero fast path
    run_op("0x9", 4'd0, 4'd9, 8'h00, 2, 1'b0);
    run_op("5x0", 4'd5, 4'd0, 8'h00, 2, 1'b0);
    // operand/Go disturbance mid-operation
    run_op("1x3", 4'd1, 4'd3, 8'h03, 11, 1'b1);

    // Reset during the 3rd SHIFT of 7x7 (LOAD=1, SHIFTs at cycles 4, 7, 10).
    @(negedge CLK);
    X = 4'd7; Y = 4'd7; Go = 1'b1;
    @(negedge CLK);
    Go = 1'b0;
    repeat (9) @(negedge CLK);
    check_eq("7x7 in_shift", 32'(CS), 32'd4);
    rst = 1'b1;
    #1;
    check_eq("abort CS", 32'(CS), 32'd0);
    check_eq("abort Busy", 32'(Busy), 32'd0);
    check_eq("abort P", 32'(P), 32'd0);
    @(negedge CLK);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (Done) seen = 1'b1;
    end
    check_eq("abort no_done", 32'(seen), 32'd0);
    run_op("2x3", 4'd2, 4'd3, 8'h06, 11, 1'b0);

    // Go held high: Done every 13 cycles with P=15.
    @(negedge CLK);
    X = 4'd3; Y = 4'd5; Go = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (Done) seen = 1'b1;
    end
    check_eq("b2b first_done", 32'(seen), 32'd1);
    check_eq("b2b P0", 32'(P), 32'd15);
    for (int k = 0; k < 2; k++) begin
      gap = 0; seen = 1'b0;
      for (int i = 1; i <= 40 && !seen; i++) begin
        @(negedge CLK);
        gap = i;
        if (Done) seen = 1'b1;
      end
      if (k == 1) Go = 1'b0;
      check_eq("b2b period", 32'(gap), 32'd13);
      check_eq("b2b P", 32'(P), 32'd15);
      check_eq("b2b Err", 32'(Err), 32'(exp_err(8'd15)));
    end
    repeat (2) @(negedge CLK);
    check_eq("b2b stop_idle", 32'(CS), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multiplier_seq.md
Name: multiplier_seq

Overview:
- Sequential shift-and-add unsigned multiplier. It is the inverse-operation counterpart of the restoring divider in the calculator.
- Uses the same Go/Done/Err handshake style as the divider.
- Holds its own FSM and datapath: accumulator A, multiplier shift register Q, multiplicand register M, and a bit counter.
- Sits beside the divider under the calculator top level. It shares the operand buses and the result mux.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- CLK  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- Go  input  1  start request; level-sampled in IDLE only.
- X  input  WIDTH  multiplier operand; must be stable from Go through the LOAD cycle.
- Y  input  WIDTH  multiplicand operand; same stability rule as X.
- P  output  2*WIDTH  product {A[WIDTH-1:0], Q}; valid when Done=1, held until the next LOAD.
- Done  output  1  one-cycle pulse in DONE state.
- Err  output  1  overflow flag, valid with Done (see Optional Feature).
- Busy  output  1  high in every state except IDLE.
- CS  output  3  current state, for debug/LED display.

Behaviour:
- Reset (rst=1, async):
  - CS=IDLE.
  - A, Q, M, count and P-source registers cleared to 0.
  - Done=0, Err=0, Busy=0.
  - Reset mid-operation aborts the operation; no Done is issued.
- State encoding: IDLE=0, LOAD=1, TEST=2, ADD=3, SHIFT=4, DONE=5. Codes 6 and 7 are illegal and transition to IDLE.
- IDLE:
  - Go=1 -> LOAD; otherwise stay.
  - Registers hold, so P keeps the last result.
- LOAD:
  - A<=0 (WIDTH+1 bits, includes carry), Q<=X, M<=Y, count<=WIDTH.
  - If X==0 or Y==0 -> DONE (zero fast path, P=0). Otherwise -> TEST.
- TEST: Q[0]=1 -> ADD; else -> SHIFT.
- ADD: A<=A+{1'b0,M}. The carry lands in A[WIDTH]; no truncation. -> SHIFT.
- SHIFT:
  - {A,Q}<={1'b0,A,Q[WIDTH-1:1]} (logical right shift of the concatenation).
  - count<=count-1.
  - If count==1 (i.e. it reaches 0) -> DONE; else -> TEST.
- DONE:
  - Done=1 for exactly one cycle; Err is valid in the same cycle. -> IDLE.
  - If Go is still high, the next cycle enters LOAD again (back-to-back ops allowed).
- Latency from Go sampled in IDLE to the Done cycle, inclusive: 2 + 2*WIDTH + popcount(X) cycles.
  - Zero fast path: 2 cycles.
- Outputs are registered or decoded from CS only; there is no combinational path from Go/X/Y to Done.
- Go asserted in any non-IDLE state is ignored. X/Y changes after LOAD have no effect.
- Count never wraps: the exit is taken at count==1 before the decrement to 0 completes.

Optional Feature:
- Macro: MUL_OVF_DETECT_EN.
- Defined: Err=1 in the DONE cycle when P[2*WIDTH-1:WIDTH]!=0, meaning the product does not fit the WIDTH-bit display/result bus. Err=0 in all other cycles.
- Undefined: Err is tied to 0. The port remains so the top-level wiring is unchanged.

Decomposition:
- Shared package calc_pkg:
  - State encoding constants MUL_IDLE..MUL_DONE.
  - Default WIDTH constant CALC_W=4, shared with the divider.
- One natural sub-module: mul_bit_counter. Loadable down counter, CNT_W bits, with LD/CE inputs and a count_one output.
- FSM and datapath stay in multiplier_seq.

Test Plan:
- WIDTH=4, X=13, Y=11, Go pulse -> Done after 2+8+3=13 cycles, P=143 (8'h8F); Err=1 with MUL_OVF_DETECT_EN, Err=0 without.
- X=15, Y=15 -> Done after 14 cycles, P=225 (8'hE1); ADD carry into A[4] exercised.
- X=0, Y=9 -> Done 2 cycles after Go, P=0, Err=0; Busy high for exactly 2 cycles.
- X=1, Y=3 -> P=3, Err=0. Change X/Y and toggle Go during TEST/ADD -> no effect on P or timing.
- Start X=7, Y=7, assert rst during the 3rd SHIFT -> CS=0, Busy=0 immediately; no Done pulse; next Go with X=2, Y=3 gives P=6.
- Hold Go=1 continuously with X=3, Y=5 -> Done pulses repeat every 2+8+2+1=13 cycles (the +1 is the IDLE cycle), P=15 each time.
